// File: rtl/exe_addsub_pipe.sv
// Pipelined integer add/subtract unit with valid/ready handshakes, tag passthrough,
// signed-saturating modes and status flags. Stage LATENCY-1 is the output stage.
module exe_addsub_pipe #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2,
  parameter int TAG_W   = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [2:0]                     op,
  input  logic [WIDTH-1:0]               a,
  input  logic [WIDTH-1:0]               b,
  input  logic [TAG_W-1:0]               tag,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               result,
  output logic [TAG_W-1:0]               out_tag,
  output logic                           carry,
  output logic                           ovf,
  output logic                           illegal,
  output logic [$clog2(LATENCY+1)-1:0]   occupancy
);

  localparam int OCC_W = $clog2(LATENCY + 1);
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   dif_w;
  logic             add_ovf;
  logic             sub_ovf;
  logic [WIDTH-1:0] res_d;
  logic             carry_d;
  logic             ovf_d;
  logic             ill_d;

  logic             adv;
  logic             accept;

  logic [LATENCY-1:0] valid_q;
  logic [WIDTH-1:0]   res_q   [LATENCY];
  logic [TAG_W-1:0]   tag_q   [LATENCY];
  logic [LATENCY-1:0] carry_q;
  logic [LATENCY-1:0] ovf_q;
  logic [LATENCY-1:0] ill_q;
  logic [OCC_W-1:0]   occ;

  assign sum_w = {1'b0, a} + {1'b0, b};
  assign dif_w = {1'b0, b} - {1'b0, a};

  // Overflow: same-sign operands whose sum flips sign; for b-a, differing signs
  // where the difference takes a's sign. The true result's sign then follows the
  // dominant operand (a for add, b for subtract).
  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif_w[WIDTH-1] != b[WIDTH-1]);

  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    ill_d   = 1'b0;
    case (op)
      3'd0: begin
        res_d   = sum_w[WIDTH-1:0];
        carry_d = sum_w[WIDTH];
        ovf_d   = add_ovf;
      end
      3'd1: begin
        res_d   = dif_w[WIDTH-1:0];
        carry_d = ~dif_w[WIDTH];
        ovf_d   = sub_ovf;
      end
      3'd2: begin
        res_d   = add_ovf ? (a[WIDTH-1] ? MIN_NEG : MAX_POS) : sum_w[WIDTH-1:0];
        carry_d = sum_w[WIDTH];
        ovf_d   = add_ovf;
      end
      3'd3: begin
        res_d   = sub_ovf ? (b[WIDTH-1] ? MIN_NEG : MAX_POS) : dif_w[WIDTH-1:0];
        carry_d = ~dif_w[WIDTH];
        ovf_d   = sub_ovf;
      end
      default: ill_d = 1'b1;
    endcase
  end

  // The whole pipe moves in lockstep; a stalled output freezes every stage.
  assign adv      = ~valid_q[LATENCY-1] | out_ready;
  assign in_ready = adv;
  assign accept   = in_valid & adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (adv) begin
      valid_q[0] <= accept;
      for (int i = 1; i < LATENCY; i++) valid_q[i] <= valid_q[i-1];
    end
  end

  // Payload registers ignore flush; their contents only matter under a valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        res_q[i] <= '0;
        tag_q[i] <= '0;
      end
      carry_q <= '0;
      ovf_q   <= '0;
      ill_q   <= '0;
    end else if (adv) begin
      res_q[0]   <= res_d;
      tag_q[0]   <= tag;
      carry_q[0] <= carry_d;
      ovf_q[0]   <= ovf_d;
      ill_q[0]   <= ill_d;
      for (int i = 1; i < LATENCY; i++) begin
        res_q[i]   <= res_q[i-1];
        tag_q[i]   <= tag_q[i-1];
        carry_q[i] <= carry_q[i-1];
        ovf_q[i]   <= ovf_q[i-1];
        ill_q[i]   <= ill_q[i-1];
      end
    end
  end

  always_comb begin
    occ = '0;
    for (int i = 0; i < LATENCY; i++) occ = occ + OCC_W'(valid_q[i]);
  end

  assign occupancy = occ;
  assign out_valid = valid_q[LATENCY-1];
  assign result    = res_q[LATENCY-1];
  assign out_tag   = tag_q[LATENCY-1];
  assign carry     = carry_q[LATENCY-1];
  assign ovf       = ovf_q[LATENCY-1];
  assign illegal   = ill_q[LATENCY-1];

endmodule

// File: tb/tb_exe_addsub_pipe.sv
// Directed bench for exe_addsub_pipe (WIDTH=32, LATENCY=2, TAG_W=4): arithmetic,
// saturation, stall hold, illegal op, flush and asynchronous reset.
module tb_exe_addsub_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  out_tag;
  logic        carry;
  logic        ovf;
  logic        illegal;
  logic [1:0]  occupancy;

  int total = 0;
  int bad   = 0;

  exe_addsub_pipe #(.WIDTH(32), .LATENCY(2), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .tag(tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_tag(out_tag),
    .carry(carry), .ovf(ovf), .illegal(illegal),
    .occupancy(occupancy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", name, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] o, input logic [31:0] av,
                               input logic [31:0] bv, input logic [3:0] t);
    in_valid = v;
    op       = o;
    a        = av;
    b        = bv;
    tag      = t;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResult(input string name, input logic [31:0] r, input logic [3:0] t,
                             input logic c, input logic o, input logic il);
    checkOutput({name, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({name, "_result"}, result, r);
    checkOutput({name, "_tag"}, 32'(out_tag), 32'(t));
    checkOutput({name, "_carry"}, 32'(carry), 32'(c));
    checkOutput({name, "_ovf"}, 32'(ovf), 32'(o));
    checkOutput({name, "_illegal"}, 32'(illegal), 32'(il));
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 4'd0);
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_result", result, 32'd0);
    checkOutput("rst_out_tag", 32'(out_tag), 32'd0);
    checkOutput("rst_flags", {29'd0, carry, ovf, illegal}, 32'd0);
    checkOutput("rst_occupancy", 32'(occupancy), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    checkOutput("rel_in_ready", 32'(in_ready), 32'd1);

    // Single add, latency 2
    applyStimulus(1'b1, 3'd0, 32'd5, 32'd7, 4'd3);
    step();
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 4'd0);
    checkOutput("add_early_valid", 32'(out_valid), 32'd0);
    checkOutput("add_occ1", 32'(occupancy), 32'd1);
    step();
    checkResult("add", 32'd12, 4'd3, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("add_drain_valid", 32'(out_valid), 32'd0);

    // Subtract, saturating subtract, saturating add back to back
    applyStimulus(1'b1, 3'd1, 32'd7, 32'd5, 4'd1);
    step();
    applyStimulus(1'b1, 3'd3, 32'd1, 32'h8000_0000, 4'd2);
    step();
    checkResult("sub", 32'hFFFF_FFFE, 4'd1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd2, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'd4);
    step();
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 4'd0);
    checkResult("subsat", 32'h8000_0000, 4'd2, 1'b1, 1'b1, 1'b0);
    step();
    checkResult("addsat", 32'h7FFF_FFFF, 4'd4, 1'b0, 1'b1, 1'b0);
    step();
    checkOutput("burst_drain_valid", 32'(out_valid), 32'd0);

    // Four-op stream with a three-cycle output stall
    applyStimulus(1'b1, 3'd0, 32'd1, 32'd100, 4'd5);
    step();
    applyStimulus(1'b1, 3'd0, 32'd2, 32'd100, 4'd6);
    step();
    checkResult("strA", 32'd101, 4'd5, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    applyStimulus(1'b1, 3'd0, 32'd3, 32'd100, 4'd7);
    #1;
    checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
    checkOutput("stall_occ", 32'(occupancy), 32'd2);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("stall_hold_valid", 32'(out_valid), 32'd1);
      checkOutput("stall_hold_result", result, 32'd101);
      checkOutput("stall_hold_tag", 32'(out_tag), 32'd5);
      checkOutput("stall_hold_in_ready", 32'(in_ready), 32'd0);
      checkOutput("stall_hold_occ", 32'(occupancy), 32'd2);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("unstall_in_ready", 32'(in_ready), 32'd1);
    step();
    checkResult("strB", 32'd102, 4'd6, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd0, 32'd4, 32'd100, 4'd8);
    step();
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 4'd0);
    checkResult("strC", 32'd103, 4'd7, 1'b0, 1'b0, 1'b0);
    step();
    checkResult("strD", 32'd104, 4'd8, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("str_drain_valid", 32'(out_valid), 32'd0);
    checkOutput("str_drain_occ", 32'(occupancy), 32'd0);

    // Illegal opcode flows through with zero result
    applyStimulus(1'b1, 3'd6, 32'd3, 32'd4, 4'd9);
    step();
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 4'd0);
    step();
    checkResult("illegal", 32'd0, 4'd9, 1'b0, 1'b0, 1'b1);
    step();

    // Flush a full pipe while a new op is offered
    applyStimulus(1'b1, 3'd0, 32'd10, 32'd10, 4'd10);
    step();
    applyStimulus(1'b1, 3'd0, 32'd20, 32'd20, 4'd11);
    step();
    checkOutput("flush_pre_occ", 32'(occupancy), 32'd2);
    applyStimulus(1'b1, 3'd0, 32'd30, 32'd30, 4'd12);
    flush = 1'b1;
    step();
    flush = 1'b0;
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 4'd0);
    checkOutput("flush_occ", 32'(occupancy), 32'd0);
    checkOutput("flush_valid", 32'(out_valid), 32'd0);
    step();
    checkOutput("flush_after1_valid", 32'(out_valid), 32'd0);
    step();
    checkOutput("flush_after2_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset between edges with a full pipe
    applyStimulus(1'b1, 3'd0, 32'd1, 32'd1, 4'd1);
    step();
    applyStimulus(1'b1, 3'd0, 32'd2, 32'd2, 4'd2);
    step();
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 4'd0);
    checkOutput("prerst_occ", 32'(occupancy), 32'd2);
    checkOutput("prerst_result", result, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", 32'(out_valid), 32'd0);
    checkOutput("arst_result", result, 32'd0);
    checkOutput("arst_occ", 32'(occupancy), 32'd0);
    checkOutput("arst_tag", 32'(out_tag), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    checkOutput("postrst_in_ready", 32'(in_ready), 32'd1);
    applyStimulus(1'b1, 3'd0, 32'd40, 32'd2, 4'd13);
    step();
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 4'd0);
    checkOutput("postrst_early_valid", 32'(out_valid), 32'd0);
    step();
    checkResult("postrst", 32'd42, 4'd13, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("postrst_drain_valid", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
